// File: rtl/seq_mul_sm.sv
// Sequential shift-add multiplier, N x N -> 2N, with per-operation signed/unsigned mode.
// Optional macro SEQ_MUL_SM_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are zero.
module seq_mul_sm #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   multiplicand,
    output logic [2*N-1:0] product,
    output logic           ready,
    output logic           busy,
    output logic [2:0]     dbg_state
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_next;

    // Handshake: start is sampled on every rising edge but is accepted only
    // when ready=1 (DONE) or in IDLE; while busy=1 it is ignored and the
    // latched operands are left untouched.
    logic           accept;

    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           mode_q;
    logic [N-1:0]   mult_q;
    logic [N-1:0]   mag_b;
    logic           neg_q;
    logic [2*N:0]   acc_q;
    logic [CW-1:0]  cnt_q;

    logic [2*N:0]   addend;
    logic [2*N:0]   acc_sum;
    logic [2*N:0]   acc_shift;
`ifdef SEQ_MUL_SM_EARLY_EXIT_EN
    logic [CW:0]    remaining;
`endif

    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        addend    = mult_q[0] ? {1'b0, mag_b, {N{1'b0}}} : '0;
        acc_sum   = acc_q + addend;
        acc_shift = acc_sum >> 1;
    end

`ifdef SEQ_MUL_SM_EARLY_EXIT_EN
    assign remaining = {1'b0, cnt_q} + (CW+1)'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef SEQ_MUL_SM_EARLY_EXIT_EN
                if (mult_q == '0 || cnt_q == '0) state_next = FIX;
`else
                if (cnt_q == '0) state_next = FIX;
`endif
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            mode_q  <= 1'b0;
            mult_q  <= '0;
            mag_b   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                op_a   <= multiplier;
                op_b   <= multiplicand;
                mode_q <= signed_mode;
            end
            case (state)
                LOAD: begin
                    // |-2^(N-1)| wraps back to 2^(N-1), which is correct as unsigned.
                    mult_q <= (mode_q && op_a[N-1]) ? -op_a : op_a;
                    mag_b  <= (mode_q && op_b[N-1]) ? -op_b : op_b;
                    neg_q  <= mode_q && (op_a[N-1] ^ op_b[N-1]);
                    acc_q  <= '0;
                    cnt_q  <= CW'(N-1);
                end
                RUN: begin
`ifdef SEQ_MUL_SM_EARLY_EXIT_EN
                    if (mult_q == '0) begin
                        // No more adds to come: apply all outstanding shifts at once.
                        acc_q <= acc_q >> remaining;
                    end else begin
                        acc_q  <= acc_shift;
                        mult_q <= mult_q >> 1;
                        cnt_q  <= cnt_q - CW'(1);
                    end
`else
                    acc_q  <= acc_shift;
                    mult_q <= mult_q >> 1;
                    cnt_q  <= cnt_q - CW'(1);
`endif
                end
                FIX: begin
                    product <= neg_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seq_mul_sm.sv
// Self-checking bench for seq_mul_sm (N=8): handshake, latency, signed/unsigned products,
// ignored restarts, back-to-back operation and reset during an operation.
module tb_seq_mul_sm;

    localparam int N      = 8;
    localparam int W      = 2 * N;
    localparam int BUDGET = 4 * N + 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         signed_mode;
    logic [N-1:0] multiplier;
    logic [N-1:0] multiplicand;
    logic [W-1:0] product;
    logic         ready;
    logic         busy;
    logic [2:0]   dbg_state;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;

    seq_mul_sm #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .ready        (ready),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [N-1:0] a, input logic s);
        int l;
        logic [N-1:0] m;
        m = (s && a[N-1]) ? -a : a;
        l = N + 2;
`ifdef SEQ_MUL_SM_EARLY_EXIT_EN
        l = 3;
        for (int i = 0; i < N; i++) if (m[i]) l = 4 + i;
        if (l > N + 2) l = N + 2;
`endif
        return l;
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input logic [W-1:0] exp, input int glitch_at);
        int lat;
        bit bad_hs;
        logic [W-1:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        start        = 1'b1;
        multiplier   = a;
        multiplicand = b;
        signed_mode  = s;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplier   = N'($urandom);
        multiplicand = N'($urandom);
        signed_mode  = 1'($urandom);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_handshake: ready=%b busy=%b, required ready=0 busy=1", ready, busy);
        end
        lat    = 0;
        bad_hs = 0;
        while (ready !== 1'b1 && lat < BUDGET) begin
            if (busy !== 1'b1) bad_hs = 1;
            if (glitch_at > 0 && lat == glitch_at) begin
                start        = 1'b1;
                multiplier   = N'($urandom);
                multiplicand = N'($urandom);
                signed_mode  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d edges, required ready=1", ready, lat);
        end
        checks++;
        if (lat !== exp_lat(a, s)) begin
            errors++;
            $display("FAIL latency a=%h b=%h s=%b: got %0d edges, required %0d", a, b, s, lat, exp_lat(a, s));
        end
        checks++;
        if (bad_hs || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_window a=%h b=%h: dropped_early=%b busy_at_done=%b, required 0 and 0", a, b, bad_hs, busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin
            errors++;
            $display("FAIL product a=%h b=%h s=%b: got %h, required %h", a, b, s, product, e);
        end
        last_exp = e;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (product !== '0 || ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: product=%h ready=%b busy=%b, required 0 0 0", product, ready, busy);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d, required 0", dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [N-1:0] ta[5] = '{8'h0F, 8'hFF, 8'h00, 8'h01, 8'h00};
        logic [N-1:0] tb[5] = '{8'h0F, 8'hFF, 8'hAB, 8'h55, 8'h55};
        logic [W-1:0] te[5] = '{16'h00E1, 16'hFE01, 16'h0000, 16'h0055, 16'h0000};
        for (int i = 0; i < 5; i++) run_op(ta[i], tb[i], 1'b0, te[i], 0);
    endtask

    task automatic test_signed();
        logic [N-1:0] ta[5] = '{8'hFF, 8'h80, 8'h80, 8'h05, 8'h00};
        logic [N-1:0] tb[5] = '{8'h02, 8'h80, 8'h7F, 8'hFD, 8'h80};
        logic [W-1:0] te[5] = '{16'hFFFE, 16'h4000, 16'hC080, 16'hFFF1, 16'h0000};
        for (int i = 0; i < 5; i++) run_op(ta[i], tb[i], 1'b1, te[i], 0);
    endtask

    task automatic test_ignore_mid_run();
        run_op(8'h37, 8'h29, 1'b0, 16'h08CF, 3);
        run_op(8'h9C, 8'h11, 1'b1, model(8'h9C, 8'h11, 1'b1), 5);
    endtask

    task automatic test_back_to_back();
        run_op(8'h0B, 8'h0D, 1'b0, 16'h008F, 0);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || product !== last_exp) begin
                errors++;
                $display("FAIL done_hold: ready=%b product=%h, required ready=1 product=%h", ready, product, last_exp);
            end
        end
        run_op(8'h03, 8'h04, 1'b0, 16'h000C, 0);
        run_op(8'hFE, 8'h7F, 1'b1, model(8'hFE, 8'h7F, 1'b1), 0);
        run_op(8'hC8, 8'h03, 1'b0, model(8'hC8, 8'h03, 1'b0), 0);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        start        = 1'b1;
        multiplier   = 8'hC3;
        multiplicand = 8'h5A;
        signed_mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (product !== '0 || ready !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_op: product=%h ready=%b busy=%b state=%0d, required 0 0 0 0",
                     product, ready, busy, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        logic s;
        for (int i = 0; i < 16; i++) begin
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, model(a, b, s), 0);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_ignore_mid_run();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
